// File: rtl/switch_debounce_sync.sv
`default_nettype none
// ============================================================================
// switch_debounce_sync
//   Two-flop synchroniser plus independent per-bit debouncer for board switches,
//   with registered per-bit rise/fall pulses and an any-change pulse.
//   Revision: 1.0
// ============================================================================
module switch_debounce_sync #(
   parameter int unsigned      WIDTH           = 8,
   parameter int unsigned      DEBOUNCE_CYCLES = 500000,
   parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_clean,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall,
   output logic             sw_changed
);

   localparam int unsigned      CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_q1;
   logic [WIDTH-1:0] sync_q2;
   logic [WIDTH-1:0] mismatch;
   logic [WIDTH-1:0] accept;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q1 <= RESET_VALUE;
         sync_q2 <= RESET_VALUE;
      end else begin
         sync_q1 <= sw_raw;
         sync_q2 <= sync_q1;
      end
   end

   // Each bit owns its counter; a mismatch that lasts DEBOUNCE_CYCLES cycles is accepted.
   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         logic [CNT_W-1:0] cnt;

         assign mismatch[i] = sync_q2[i] ^ sw_clean[i];
         assign accept[i]   = mismatch[i] && (cnt == CNT_LAST);

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt <= '0;
            end else if (!mismatch[i] || accept[i]) begin
               cnt <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   endgenerate

   // Accepting a bit always flips it, so the pulse direction is the newly sampled level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sw_clean   <= RESET_VALUE;
         sw_rise    <= '0;
         sw_fall    <= '0;
         sw_changed <= 1'b0;
      end else begin
         sw_clean   <= sw_clean ^ accept;
         sw_rise    <= accept & sync_q2;
         sw_fall    <= accept & ~sync_q2;
         sw_changed <= |accept;
      end
   end

endmodule
`default_nettype wire
